// File: rtl/mac_pkg.sv
// Shared defaults and FSM state encoding for the MAC sequencing controller.
package mac_pkg;

    localparam int BW_DEF      = 4;
    localparam int PSUM_BW_DEF = 16;
    localparam int LEN_W       = 8;
    localparam int WAIT_W      = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/mac_seq_ctrl.sv
// Sequences a dot-product job through an external MAC one 4-element group
// at a time, feeding the running sum back as psum_in and presenting the
// final accumulator through a valid/ready handshake.
module mac_seq_ctrl
    import mac_pkg::*;
#(
    parameter int bw      = BW_DEF,
    parameter int psum_bw = PSUM_BW_DEF,
    parameter int MAC_LAT = 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [LEN_W-1:0]   len,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [4*bw-1:0]    x_in,
    input  logic [4*bw-1:0]    w_in,
    output logic [4*bw-1:0]    mac_x,
    output logic [4*bw-1:0]    mac_w,
    output logic [psum_bw-1:0] mac_psum,
    input  logic [psum_bw-1:0] mac_out,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [psum_bw-1:0] out_psum,
    output logic               busy
);

    localparam logic [WAIT_W-1:0] LAT_LOAD = WAIT_W'(MAC_LAT);

    state_t                    state;
    state_t                    state_nxt;
    logic [LEN_W-1:0]          len_q;
    logic [LEN_W-1:0]          cnt_q;
    logic [WAIT_W-1:0]         wait_q;
    logic signed [psum_bw-1:0] acc;

    logic job_clear;
    logic grp_accept;
    logic grp_capture;

    // The group being captured is the last one when the incremented count
    // reaches the latched length; widened so len=255 cannot wrap.
    function automatic logic is_last_group(input logic [LEN_W-1:0] cnt,
                                           input logic [LEN_W-1:0] total);
        return ({1'b0, cnt} + {{LEN_W{1'b0}}, 1'b1}) == {1'b0, total};
    endfunction

    assign out_psum = acc;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, handshake outputs and datapath strobes; reset masks every
    // handshake so nothing can be accepted or emitted while it is asserted.
    always_comb begin
        state_nxt   = state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        busy        = 1'b0;
        job_clear   = 1'b0;
        grp_accept  = 1'b0;
        grp_capture = 1'b0;
        if (!reset) begin
            busy = (state != ST_IDLE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        job_clear = 1'b1;
                        state_nxt = (len != '0) ? ST_FETCH : ST_DONE;
                    end
                end
                ST_FETCH: begin
                    in_ready = 1'b1;
                    if (in_valid) begin
                        grp_accept = 1'b1;
                        state_nxt  = ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (wait_q == WAIT_W'(1)) begin
                        grp_capture = 1'b1;
                        state_nxt   = is_last_group(cnt_q, len_q) ? ST_DONE : ST_FETCH;
                    end
                end
                ST_DONE: begin
                    out_valid = 1'b1;
                    if (out_ready) begin
                        state_nxt = ST_IDLE;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Job bookkeeping, MAC operand registers and accumulator capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_q    <= '0;
            cnt_q    <= '0;
            wait_q   <= '0;
            acc      <= '0;
            mac_x    <= '0;
            mac_w    <= '0;
            mac_psum <= '0;
        end else begin
            if (job_clear) begin
                len_q <= len;
                cnt_q <= '0;
                acc   <= '0;
            end
            if (grp_accept) begin
                mac_x    <= x_in;
                mac_w    <= w_in;
                mac_psum <= acc;
                wait_q   <= LAT_LOAD;
            end
            if (state == ST_WAIT) begin
                wait_q <= wait_q - WAIT_W'(1);
            end
            if (grp_capture) begin
                acc   <= mac_out;
                cnt_q <= cnt_q + LEN_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// Bench for mac_seq_ctrl paired with a behavioural single-cycle MAC.
module tb_mac_seq_ctrl;

    localparam int BW   = 4;
    localparam int PSW  = 16;
    localparam int LAT  = 1;

    logic            clk = 1'b0;
    logic            reset;
    logic            start;
    logic [7:0]      len;
    logic            in_valid;
    logic            in_ready;
    logic [4*BW-1:0] x_in;
    logic [4*BW-1:0] w_in;
    logic [4*BW-1:0] mac_x;
    logic [4*BW-1:0] mac_w;
    logic [PSW-1:0]  mac_psum;
    logic [PSW-1:0]  mac_out;
    logic            out_valid;
    logic            out_ready;
    logic [PSW-1:0]  out_psum;
    logic            busy;

    int tests = 0;
    int fails = 0;
    int ecnt  = 0;

    logic [15:0] gx [0:255];
    logic [15:0] gw [0:255];

    typedef struct {
        logic [7:0]  len;
        logic [15:0] x0;
        logic [15:0] w0;
        logic [15:0] x1;
        logic [15:0] w1;
        int          gap;
        int          ostall;
        logic [15:0] exp_psum;
        int          exp_lat;
    } vec_t;

    vec_t vecs [6];

    always #5 clk = ~clk;

    mac_seq_ctrl #(.bw(BW), .psum_bw(PSW), .MAC_LAT(LAT)) dut (
        .clk(clk), .reset(reset), .start(start), .len(len),
        .in_valid(in_valid), .in_ready(in_ready), .x_in(x_in), .w_in(w_in),
        .mac_x(mac_x), .mac_w(mac_w), .mac_psum(mac_psum), .mac_out(mac_out),
        .out_valid(out_valid), .out_ready(out_ready), .out_psum(out_psum),
        .busy(busy)
    );

    // Dot product of one group: unsigned activations times signed weights.
    function automatic int dot4(input logic [15:0] x, input logic [15:0] w);
        int s;
        logic [3:0] xe;
        logic [3:0] we;
        s = 0;
        for (int k = 0; k < 4; k++) begin
            xe = x[k*4 +: 4];
            we = w[k*4 +: 4];
            s += int'(xe) * int'($signed(we));
        end
        return s;
    endfunction

    // Behavioural stand-in for mac_wrapper with one cycle of latency:
    // combinational from the controller's registered operands.
    always_comb mac_out = 16'(int'(mac_psum) + dot4(mac_x, mac_w));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        tests++;
        fails++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        ecnt++;
    endtask

    // Starts a job and keeps start high (it must be ignored while busy);
    // len is scrambled after acceptance.
    task automatic start_job(input logic [7:0] ln);
        start = 1'b1;
        len   = ln;
        tick();
        ecnt = 0;
        len  = 8'($urandom);
        check("busy_after_start", 32'(busy), 32'd1);
    endtask

    task automatic send_group(input logic [15:0] x, input logic [15:0] w,
                              input int gap, input logic [15:0] psum_exp);
        int n;
        n = 0;
        while (!in_ready && n < 50) begin
            tick();
            n++;
        end
        if (!in_ready) begin
            timeout("in_ready_wait");
        end else begin
            for (int g = 0; g < gap; g++) begin
                x_in = 16'($urandom);
                w_in = 16'($urandom);
                tick();
                check("fetch_hold_ready", 32'(in_ready), 32'd1);
            end
            x_in     = x;
            w_in     = w;
            in_valid = 1'b1;
            tick();
            in_valid = 1'b0;
            check("mac_x_reg", 32'(mac_x), 32'(x));
            check("mac_w_reg", 32'(mac_w), 32'(w));
            check("mac_psum_reg", 32'(mac_psum), 32'(psum_exp));
        end
    endtask

    task automatic finish_job(input logic [15:0] exp_psum, input int exp_lat, input int ostall);
        int n;
        start     = 1'b0;
        out_ready = 1'b0;
        n = 0;
        while (!out_valid && n < 2000) begin
            tick();
            n++;
        end
        if (!out_valid) begin
            timeout("out_valid_wait");
        end else begin
            check("done_latency", 32'(ecnt), 32'(exp_lat));
            check("out_psum", 32'(out_psum), 32'(exp_psum));
            check("done_in_ready_low", 32'(in_ready), 32'd0);
            for (int s = 0; s < ostall; s++) begin
                tick();
                check("stall_out_valid", 32'(out_valid), 32'd1);
                check("stall_out_psum", 32'(out_psum), 32'(exp_psum));
                check("stall_busy", 32'(busy), 32'd1);
            end
            out_ready = 1'b1;
            tick();
            out_ready = 1'b0;
            check("idle_out_valid", 32'(out_valid), 32'd0);
            check("idle_busy", 32'(busy), 32'd0);
        end
    endtask

    // Runs one job over gx/gw; the expected partial sums come from the
    // arithmetic model, the final value and latency from the caller.
    task automatic run_job(input logic [7:0] ln, input int gap, input int ostall,
                           input logic [15:0] exp_psum, input int exp_lat);
        int part;
        part = 0;
        start_job(ln);
        for (int g = 0; g < int'(ln); g++) begin
            send_group(gx[g], gw[g], gap, 16'(part));
            part += dot4(gx[g], gw[g]);
        end
        finish_job(exp_psum, exp_lat, ostall);
    endtask

    initial begin
        int total;
        logic [7:0] rl;
        int rgap;
        int rst_n;

        reset = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
        x_in = '0; w_in = '0; out_ready = 1'b0;
        tick();
        tick();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_psum", 32'(out_psum), 32'd0);
        check("rst_mac_x", 32'(mac_x), 32'd0);
        check("rst_mac_w", 32'(mac_w), 32'd0);
        check("rst_mac_psum", 32'(mac_psum), 32'd0);
        reset = 1'b0;
        tick();

        // len, x0, w0, x1, w1, gap, ostall, expected psum, expected latency
        vecs[0] = '{8'd1,   16'h4321, 16'hE2F1, 16'h0000, 16'h0000, 0, 0, 16'hFFFD, 2};
        vecs[1] = '{8'd2,   16'h4321, 16'hE2F1, 16'hFFFF, 16'h8888, 0, 0, 16'hFE1D, 4};
        vecs[2] = '{8'd0,   16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0};
        vecs[3] = '{8'd2,   16'h4321, 16'hE2F1, 16'hFFFF, 16'h8888, 3, 4, 16'hFE1D, 10};
        vecs[4] = '{8'd1,   16'h1111, 16'h1111, 16'h0000, 16'h0000, 0, 1, 16'h0004, 2};
        vecs[5] = '{8'd200, 16'hFFFF, 16'h7777, 16'hFFFF, 16'h7777, 0, 0, 16'h4820, 400};

        for (int i = 0; i < 6; i++) begin
            for (int g = 0; g < int'(vecs[i].len); g++) begin
                gx[g] = (g == 0) ? vecs[i].x0 : vecs[i].x1;
                gw[g] = (g == 0) ? vecs[i].w0 : vecs[i].w1;
            end
            run_job(vecs[i].len, vecs[i].gap, vecs[i].ostall, vecs[i].exp_psum, vecs[i].exp_lat);
        end

        // Reset while the second group is in WAIT: job aborted, nothing emitted.
        gx[0] = 16'h4321; gw[0] = 16'hE2F1;
        start_job(8'd2);
        send_group(16'h4321, 16'hE2F1, 0, 16'h0000);
        send_group(16'hFFFF, 16'h8888, 0, 16'hFFFD);
        reset = 1'b1;
        start = 1'b0;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd0);
        check("abort_out_psum", 32'(out_psum), 32'd0);
        check("abort_mac_x", 32'(mac_x), 32'd0);
        check("abort_mac_w", 32'(mac_w), 32'd0);
        check("abort_mac_psum", 32'(mac_psum), 32'd0);
        rst_n = 0;
        for (int c = 0; c < 4; c++) begin
            tick();
            if (out_valid) rst_n++;
        end
        check("abort_no_result", 32'(rst_n), 32'd0);
        out_ready = 1'b0;
        gx[0] = 16'h1111; gw[0] = 16'h1111;
        run_job(8'd1, 0, 0, 16'h0004, 2);

        // Reset while DONE is stalled by out_ready low.
        gx[0] = 16'h4321; gw[0] = 16'hE2F1;
        start_job(8'd1);
        send_group(16'h4321, 16'hE2F1, 0, 16'h0000);
        start = 1'b0;
        tick();
        check("pre_abort_done_valid", 32'(out_valid), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("done_abort_valid", 32'(out_valid), 32'd0);
        check("done_abort_psum", 32'(out_psum), 32'd0);
        tick();
        check("done_abort_stays_idle", 32'(busy), 32'd0);

        // Randomised jobs against the arithmetic model.
        for (int j = 0; j < 30; j++) begin
            rl   = 8'($urandom_range(0, 6));
            rgap = int'($urandom_range(0, 3));
            total = 0;
            for (int g = 0; g < int'(rl); g++) begin
                gx[g] = 16'($urandom);
                gw[g] = 16'($urandom);
                total += dot4(gx[g], gw[g]);
            end
            run_job(rl, rgap, int'($urandom_range(0, 3)), 16'(total), int'(rl) * (1 + LAT + rgap));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mac_seq_ctrl.md
MAC_SEQ_CTRL -- requirements
Module: mac_seq_ctrl

Interface
REQ-001 SHALL have parameter bw, default 4: activation/weight element width.
REQ-002 SHALL have parameter psum_bw, default 16: partial-sum width.
REQ-003 SHALL have parameter MAC_LAT, default 1, legal range 1..7: MAC input-to-output latency in clk cycles.
REQ-004 SHALL have port clk, input, 1 bit: single clock, all state on rising edge.
REQ-005 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-006 SHALL have port start, input, 1 bit: begin a dot-product job (sampled in IDLE only).
REQ-007 SHALL have port len, input, 8 bits: number of 4-element groups in the job, sampled with start.
REQ-008 SHALL have port in_valid, input, 1 bit: x_in/w_in group valid.
REQ-009 SHALL have port in_ready, output, 1 bit: controller accepts a group.
REQ-010 SHALL have port x_in, input, 4*bw bits: four unsigned activations, element k at [k*bw +: bw].
REQ-011 SHALL have port w_in, input, 4*bw bits: four two's-complement weights, same packing.
REQ-012 SHALL have ports mac_x, mac_w, outputs, 4*bw bits each: registered operands to the external MAC, x0/w0 at the LSBs.
REQ-013 SHALL have port mac_psum, output, psum_bw bits: registered psum_in to the MAC.
REQ-014 SHALL have port mac_out, input, psum_bw bits: MAC result.
REQ-015 SHALL have ports out_valid (output, 1 bit), out_ready (input, 1 bit), and out_psum (output, psum_bw bits): final result handshake.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement states IDLE, FETCH, WAIT, DONE.
REQ-018 In IDLE, start=1 with len!=0 SHALL clear acc and the group count, latch len, and go to FETCH; start=1 with len=0 SHALL clear acc and go to DONE.
REQ-019 In FETCH, in_ready SHALL be 1; on in_valid&in_ready, it SHALL register mac_x<=x_in, mac_w<=w_in, and mac_psum<=acc, load wait counter=MAC_LAT, and go to WAIT; without in_valid it SHALL stay in FETCH indefinitely.
REQ-020 in_ready SHALL be 0 in all states other than FETCH.
REQ-021 In WAIT, the counter SHALL decrement each cycle; on the MAC_LAT-th edge after the handshake edge, acc<=mac_out and the group count SHALL increment.
REQ-022 At that capture edge, the FSM SHALL go to DONE if count+1==len, else to FETCH.
REQ-023 Each group SHALL take exactly 1+MAC_LAT cycles when in_valid is held high; a job of N groups accepted at edge S SHALL have out_valid=1 in the cycle after edge S+N*(1+MAC_LAT).
REQ-024 In DONE, out_valid SHALL be 1 and out_psum SHALL equal acc, both held stable until out_ready=1; the handshake edge SHALL return the FSM to IDLE.
REQ-025 start SHALL be ignored outside IDLE; len changes after acceptance SHALL have no effect.
REQ-026 Arithmetic SHALL be modulo 2^psum_bw (wrap, no saturation, no overflow flag); the controller SHALL perform no arithmetic beyond the count compare.
REQ-027 mac_x, mac_w, and mac_psum SHALL hold their values outside the FETCH handshake.

Reset
REQ-028 While reset=1 at a clk edge, the state SHALL go to IDLE and acc, count, wait counter, mac_x, mac_w, mac_psum, and out_psum SHALL be 0; out_valid, in_ready, and busy SHALL be 0.
REQ-029 Reset in any state, including mid-WAIT or DONE with out_ready=0, SHALL abort the job with no result emitted; reset SHALL take priority over start and all handshakes.

Structure
REQ-030 Package mac_pkg SHALL hold the bw/psum_bw defaults and the state enum.
REQ-031 The block SHALL be a single module with no sub-modules; the parent SHALL instantiate mac_wrapper beside it and wire mac_x/mac_w/mac_psum/mac_out.

Verification (bench pairs the block with mac_wrapper; MAC_LAT=1)
REQ-032 len=1, x={1,2,3,4}, w={1,-1,2,-2} -> out_psum=0xFFFD (-3), out_valid first seen in the cycle after edge S+2.
REQ-033 len=2, groups {1,2,3,4}/{1,-1,2,-2} then {15,15,15,15}/{-8,-8,-8,-8} -> out_psum=0xFE1D (-483).
REQ-034 len=0 -> out_valid=1 in the cycle after the start edge, out_psum=0, in_ready never asserted.
REQ-035 in_valid low for 3 cycles between groups and out_ready low for 4 cycles in DONE -> same result as REQ-033, out_psum stable while stalled, busy high throughout.
REQ-036 reset pulsed in WAIT of group 2, then a new len=1 job {1,1,1,1}/{1,1,1,1} -> out_psum=4 with no stale accumulation; start asserted while busy -> ignored.
